// File: rtl/rv_mem_pkg.sv
// Shared encodings and constants for the data-memory request path.
package rv_mem_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam logic [31:0] RESET_PC       = 32'h0000_0000;
    localparam logic [31:0] DMEM_BASE_ADDR = 32'h0100_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } dmem_state_e;

    // Natural-alignment check; the illegal size is flagged separately.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the M stage (master) and the responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_address;
    logic        req_read_write;
    logic [1:0]  req_access_size;
    logic        req_unsigned;
    logic [31:0] req_data_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        console_valid;
    logic [7:0]  console_byte;

    modport master (
        output req_valid, req_address, req_read_write, req_access_size,
               req_unsigned, req_data_in, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_error, console_valid, console_byte
    );

    modport slave (
        input  req_valid, req_address, req_read_write, req_access_size,
               req_unsigned, req_data_in, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_error, console_valid, console_byte
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane alignment: store merge with byte enables, load lane select and extension.
module dmem_lane_align
    import rv_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_merged,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_load_val
);

    logic [31:0] w_rep;
    logic [31:0] w_shifted;

    assign w_shifted = i_old_word >> {i_addr_lo, 3'b000};

    // Replicate store data across lanes so each enabled lane sees the right bytes.
    always_comb begin
        w_rep     = i_store_data;
        o_byte_en = 4'b0000;
        case (i_size)
            SIZE_BYTE: begin
                w_rep     = {4{i_store_data[7:0]}};
                o_byte_en = 4'b0001 << i_addr_lo;
            end
            SIZE_HALF: begin
                w_rep     = {2{i_store_data[15:0]}};
                o_byte_en = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_WORD: begin
                w_rep     = i_store_data;
                o_byte_en = 4'b1111;
            end
            default: begin
                w_rep     = i_store_data;
                o_byte_en = 4'b0000;
            end
        endcase
    end

    // Byte-enable merge of the replicated store data into the old word.
    always_comb begin
        o_merged = i_old_word;
        for (int i = 0; i < 4; i++) begin
            if (o_byte_en[i]) begin
                o_merged[8*i +: 8] = w_rep[8*i +: 8];
            end else begin
                o_merged[8*i +: 8] = i_old_word[8*i +: 8];
            end
        end
    end

    // Load path: the addressed lane is already at bit 0 of the shifted word.
    always_comb begin
        o_load_val = 32'h0000_0000;
        case (i_size)
            SIZE_BYTE: o_load_val = i_unsigned ? {24'h00_0000, w_shifted[7:0]}
                                               : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SIZE_HALF: o_load_val = i_unsigned ? {16'h0000, w_shifted[15:0]}
                                               : {{16{w_shifted[15]}}, w_shifted[15:0]};
            SIZE_WORD: o_load_val = w_shifted;
            default:   o_load_val = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with configurable wait states; DMEM_CONSOLE_EN adds a store-only console port.
module dmem_responder
    import rv_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = DMEM_BASE_ADDR,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          WAIT_CYCLES  = 1,
    parameter logic [31:0] CONSOLE_ADDR = 32'h0200_0000
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e r_state;
    dmem_state_e w_next_state;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic          r_req_ready;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_data;
    logic          r_rsp_error;
    logic [3:0]    r_cnt;

    logic [1:0]    r_addr_lo;
    logic [AW-1:0] r_index;
    logic          r_rw;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [31:0]   r_data;
    logic          r_err;
    logic          r_console;

    logic [29:0]   w_in_word_off;
    logic          w_in_range;
    logic          w_in_console;
    logic          w_in_err;
    logic          w_accept;
    logic          w_commit;
    logic          w_rsp_done;
    logic          w_store_en;
    logic [31:0]   w_old_word;
    logic [31:0]   w_merged;
    logic [3:0]    w_byte_en;
    logic [31:0]   w_load_val;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    assign w_in_word_off = bus.req_address[31:2] - BASE_ADDR[31:2];
    assign w_in_range    = (w_in_word_off[29:AW] == '0);

`ifdef DMEM_CONSOLE_EN
    logic       r_console_valid;
    logic [7:0] r_console_byte;

    assign w_in_console = (bus.req_address == CONSOLE_ADDR) &&
                          (bus.req_read_write ? ((bus.req_access_size == SIZE_BYTE) ||
                                                 (bus.req_access_size == SIZE_WORD))
                                              : (bus.req_access_size != SIZE_ILLEGAL));

    // Console character pulse, raised on the same edge the response appears.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_console_valid <= 1'b0;
            r_console_byte  <= 8'h00;
        end else if (w_commit && r_console && r_rw) begin
            r_console_valid <= 1'b1;
            r_console_byte  <= r_data[7:0];
        end else begin
            r_console_valid <= 1'b0;
        end
    end

    assign bus.console_valid = r_console_valid;
    assign bus.console_byte  = r_console_byte;
`else
    logic w_unused_cfg;
    assign w_unused_cfg      = ^CONSOLE_ADDR;
    assign w_in_console      = 1'b0;
    assign bus.console_valid = 1'b0;
    assign bus.console_byte  = 8'h00;
`endif

    assign w_in_err = !w_in_console &&
                      ((bus.req_access_size == SIZE_ILLEGAL) ||
                       misaligned(bus.req_access_size, bus.req_address[1:0]) ||
                       !w_in_range);

    assign w_old_word = r_mem[r_index];
    assign w_store_en = w_commit && r_rw && !r_err && !r_console && (w_byte_en != 4'b0000);

    dmem_lane_align u_align (
        .i_size       (r_size),
        .i_addr_lo    (r_addr_lo),
        .i_unsigned   (r_unsigned),
        .i_old_word   (w_old_word),
        .i_store_data (r_data),
        .o_merged     (w_merged),
        .o_byte_en    (w_byte_en),
        .o_load_val   (w_load_val)
    );

    // Next-state logic; the first RESP cycle commits the access, later ones wait for rsp_ready.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = (w_in_err || (WAIT_CYCLES == 0)) ? ST_RESP : ST_WAIT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'(WAIT_CYCLES - 1)) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (!r_rsp_valid) begin
                    w_commit     = !reset;
                    w_next_state = ST_RESP;
                end else if (bus.rsp_ready) begin
                    w_rsp_done   = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state, request capture and registered response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0000_0000;
            r_rsp_error <= 1'b0;
            r_cnt       <= 4'h0;
            r_addr_lo   <= 2'b00;
            r_index     <= '0;
            r_rw        <= 1'b0;
            r_size      <= SIZE_BYTE;
            r_unsigned  <= 1'b0;
            r_data      <= 32'h0000_0000;
            r_err       <= 1'b0;
            r_console   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_req_ready <= (w_next_state == ST_IDLE);
            r_cnt       <= ((r_state == ST_WAIT) && (w_next_state == ST_WAIT)) ? r_cnt + 4'h1 : 4'h0;
            if (w_accept) begin
                r_addr_lo  <= bus.req_address[1:0];
                r_index    <= w_in_word_off[AW-1:0];
                r_rw       <= bus.req_read_write;
                r_size     <= bus.req_access_size;
                r_unsigned <= bus.req_unsigned;
                r_data     <= bus.req_data_in;
                r_err      <= w_in_err;
                r_console  <= w_in_console;
            end
            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_error <= r_err;
                r_rsp_data  <= (r_err || r_rw || r_console) ? 32'h0000_0000 : w_load_val;
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
                r_rsp_error <= 1'b0;
                r_rsp_data  <= 32'h0000_0000;
            end
        end
    end

    // Storage array: contents survive reset; a store commits exactly once.
    always_ff @(posedge clock) begin
        if (w_store_en) begin
            r_mem[r_index] <= w_merged;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_error = r_rsp_error;

endmodule
